// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter.
// Request lines are captured into a sticky pending vector. One binary index
// at a time is presented on a valid/ack handshake, using either fixed
// priority (lowest index wins) or round-robin selection. A grant stays held
// until the consumer acknowledges it or enable withdraws it.
module prio_encoder_arb #(
    parameter int N    = 8,
    parameter bit EDGE = 1'b1,
    parameter bit RR   = 1'b0,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state;
    logic [N-1:0] req_q;
    logic [W-1:0] rr_ptr;

    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic [N-1:0] pending_next;
    logic [N-1:0] hi_mask;
    logic [N-1:0] pending_hi;
    logic         grant_accept;
    logic         any_pending;
    logic [W-1:0] sel_idx;

    // Returns the lowest set index of v (0 when v is empty).
    function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = W'(i);
            end
        end
        return r;
    endfunction

    // A live grant is consumed only when the consumer acks while enabled.
    assign grant_accept = (state == GRANT) & valid & ack & enable;

    // Per-line set/clear events and the round-robin "above pointer" mask.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_line
            if (EDGE) begin : g_edge
                assign set_vec[gi] = req[gi] & ~req_q[gi];
            end else begin : g_level
                assign set_vec[gi] = req[gi];
            end
            assign clr_vec[gi] = grant_accept & (y == W'(gi));
            assign hi_mask[gi] = (W'(gi) > rr_ptr);
        end
    endgenerate

    // Set wins over clear when both hit the same bit in one cycle.
    assign pending_next = (pending & ~clr_vec) | set_vec;
    assign any_pending  = |pending;
    assign pending_hi   = pending & hi_mask;

    // Pick the next index from the current pending register. Round-robin
    // first looks above the last granted index, then wraps to index 0.
    always_comb begin
        sel_idx = lowest_index(pending);
        if (RR) begin
            if (|pending_hi) begin
                sel_idx = lowest_index(pending_hi);
            end
        end
    end

    // Capture requests into pending and flag set events on pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= pending_next;
            overrun <= |(set_vec & pending & ~clr_vec);
        end
    end

    // Grant handshake FSM: load a selection in IDLE, hold it in GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            y      <= '0;
            valid  <= 1'b0;
            rr_ptr <= W'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (enable && any_pending) begin
                        y     <= sel_idx;
                        valid <= 1'b1;
                        state <= GRANT;
                        if (RR) begin
                            rr_ptr <= sel_idx;
                        end
                    end else begin
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    // Either consumed or withdrawn; pending only clears on ack.
                    if (!enable || ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Bench for prio_encoder_arb: a fixed-priority edge-capture instance and a
// round-robin level-capture instance share one stimulus stream. Each cycle
// both are compared with a behavioural model; directed steps add explicit
// checks for the interesting cases.
module tb_prio_encoder_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ack;
    logic [7:0] req;

    logic [2:0] y0, y1;
    logic       v0, v1, o0, o1;
    logic [7:0] p0, p1;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = fixed/edge, index 1 = round-robin/level
    logic [7:0] m_pend[2];
    logic [7:0] m_reqq[2];
    logic       m_valid[2];
    logic       m_ovr[2];
    int         m_y[2];
    int         m_ptr[2];

    int fp_q[$];
    int rr_q[$];

    always #5 clk = ~clk;

    prio_encoder_arb #(.N(8), .EDGE(1'b1), .RR(1'b0)) u_fp (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .ack(ack),
        .y(y0), .valid(v0), .pending(p0), .overrun(o0)
    );

    prio_encoder_arb #(.N(8), .EDGE(1'b0), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .ack(ack),
        .y(y1), .valid(v1), .pending(p1), .overrun(o1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c]  = 8'h00;
            m_reqq[c]  = 8'h00;
            m_valid[c] = 1'b0;
            m_ovr[c]   = 1'b0;
            m_y[c]     = 0;
            m_ptr[c]   = 7;
        end
    endfunction

    // Fixed priority: lowest index. Round-robin: first hit after last grant.
    function automatic int pick(int c, logic [7:0] p);
        if (c == 0) begin
            for (int i = 0; i < 8; i++) if (p[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (m_ptr[c] + k) % 8;
                if (p[idx]) return idx;
            end
        end
        return 0;
    endfunction

    function automatic void model_step();
        for (int c = 0; c < 2; c++) begin
            logic [7:0] setv;
            logic [7:0] clrv;
            logic [7:0] np;
            setv = (c == 0) ? (req & ~m_reqq[c]) : req;
            clrv = (m_valid[c] && ack && enable) ? (8'h01 << m_y[c]) : 8'h00;
            np = (m_pend[c] & ~clrv) | setv;
            m_ovr[c] = |(setv & m_pend[c] & ~clrv);
            if (m_valid[c]) begin
                if (!enable || ack) m_valid[c] = 1'b0;
            end else if (enable && m_pend[c] != 8'h00) begin
                m_y[c] = pick(c, m_pend[c]);
                m_valid[c] = 1'b1;
                if (c == 1) m_ptr[c] = m_y[c];
            end
            m_pend[c] = np;
            m_reqq[c] = req;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".fp.y"},   32'(y0), 32'(m_y[0]));
        chk({tag, ".fp.v"},   32'(v0), 32'(m_valid[0]));
        chk({tag, ".fp.pnd"}, 32'(p0), 32'(m_pend[0]));
        chk({tag, ".fp.ovr"}, 32'(o0), 32'(m_ovr[0]));
        chk({tag, ".rr.y"},   32'(y1), 32'(m_y[1]));
        chk({tag, ".rr.v"},   32'(v1), 32'(m_valid[1]));
        chk({tag, ".rr.pnd"}, 32'(p1), 32'(m_pend[1]));
        chk({tag, ".rr.ovr"}, 32'(o1), 32'(m_ovr[1]));
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic cycle(input logic [7:0] r, input logic a, input logic e, input string tag);
        req = r;
        ack = a;
        enable = e;
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
        if (v0) fp_q.push_back(int'(y0));
        if (v1) rr_q.push_back(int'(y1));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_fp[3];
        int exp_rr[4];
        exp_fp = '{1, 4, 7};
        exp_rr = '{0, 7, 0, 7};

        rst = 1'b1;
        req = 8'h00;
        ack = 1'b0;
        enable = 1'b1;
        model_reset();
        #3;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single request held without ack
        cycle(8'h20, 1'b0, 1'b1, "single.cap");
        chk("single.pend", 32'(p0), 32'h20);
        cycle(8'h00, 1'b0, 1'b1, "single.grant");
        chk("single.y", 32'(y0), 32'd5);
        chk("single.valid", 32'(v0), 32'd1);
        for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0, 1'b1, "single.hold");
        chk("single.hold.y", 32'(y0), 32'd5);
        cycle(8'h00, 1'b1, 1'b1, "single.ack");
        chk("single.ack.v", 32'(v0), 32'd0);
        chk("single.ack.pnd", 32'(p0), 32'd0);

        // fixed priority order 1,4,7
        fp_q.delete();
        cycle(8'h92, 1'b1, 1'b1, "fixprio");
        for (int i = 0; i < 6; i++) cycle(8'h00, 1'b1, 1'b1, "fixprio");
        chk("fixprio.count", 32'(fp_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("fixprio.order", (i < fp_q.size()) ? 32'(fp_q[i]) : 32'hFFFF, 32'(exp_fp[i]));

        // round-robin alternation from reset
        req = 8'h00;
        do_reset("rr.rst");
        rr_q.delete();
        for (int i = 0; i < 9; i++) cycle(8'h81, 1'b1, 1'b1, "rr");
        chk("rr.count", 32'(rr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("rr.order", (i < rr_q.size()) ? 32'(rr_q[i]) : 32'hFFFF, 32'(exp_rr[i]));
        chk("rr.pend0", 32'(p1[0]), 32'd1);

        // overrun and simultaneous set/clear
        req = 8'h00;
        do_reset("ovr.rst");
        cycle(8'h08, 1'b0, 1'b1, "ovr.cap");
        cycle(8'h00, 1'b0, 1'b1, "ovr.grant");
        chk("ovr.y", 32'(y0), 32'd3);
        cycle(8'h08, 1'b0, 1'b1, "ovr.hit");
        chk("ovr.pulse", 32'(o0), 32'd1);
        cycle(8'h00, 1'b0, 1'b1, "ovr.fall");
        chk("ovr.pulse_end", 32'(o0), 32'd0);
        cycle(8'h08, 1'b1, 1'b1, "ovr.setclr");
        chk("ovr.setclr.o", 32'(o0), 32'd0);
        chk("ovr.setclr.p3", 32'(p0[3]), 32'd1);
        chk("ovr.setclr.v", 32'(v0), 32'd0);
        cycle(8'h00, 1'b0, 1'b1, "ovr.regrant");
        chk("ovr.regrant.y", 32'(y0), 32'd3);
        chk("ovr.regrant.v", 32'(v0), 32'd1);
        cycle(8'h00, 1'b1, 1'b1, "ovr.done");

        // enable withdrawal
        do_reset("en.rst");
        cycle(8'h04, 1'b0, 1'b1, "en.cap");
        cycle(8'h00, 1'b0, 1'b1, "en.grant");
        chk("en.y", 32'(y0), 32'd2);
        for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, 1'b0, "en.off");
        chk("en.off.v", 32'(v0), 32'd0);
        chk("en.off.p2", 32'(p0[2]), 32'd1);
        cycle(8'h00, 1'b0, 1'b1, "en.on");
        chk("en.on.y", 32'(y0), 32'd2);
        chk("en.on.v", 32'(v0), 32'd1);

        // async reset mid-grant, release with req[0] high
        req = 8'h01;
        do_reset("arst");
        chk("arst.v", 32'(v0), 32'd0);
        chk("arst.pnd", 32'(p0), 32'd0);
        cycle(8'h01, 1'b0, 1'b1, "arst.cap");
        chk("arst.cap.p", 32'(p0), 32'h01);
        cycle(8'h01, 1'b0, 1'b1, "arst.grant");
        chk("arst.grant.y", 32'(y0), 32'd0);
        chk("arst.grant.v", 32'(v0), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            logic a, e;
            r = 8'($urandom) & 8'($urandom);
            a = ($urandom % 3) != 0;
            e = ($urandom % 8) != 0;
            cycle(r, a, e, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
